// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-deep valid/ready holding register.
// Flags framing errors (stop bit low) and overruns (byte lost while holding reg is full).
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bitn;
  logic [7:0]             shreg;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bitn == 3'd7) state <= S_STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Sampled at mid-stop so IDLE is back in time for a back-to-back start edge.
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: latency, back-to-back, overrun, glitch, framing, reset.
module tb_uart_rx;

  localparam int CBP = 104;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         n_valid_cyc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_both = 0;

  uart_rx #(.CLKS_PER_BIT(CBP), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge; a byte counts as delivered when valid&&ready.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_q.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (valid)     n_valid_cyc = n_valid_cyc + 1;
    if (frame_err) n_ferr = n_ferr + 1;
    if (overrun)   n_ovr = n_ovr + 1;
    if (frame_err && overrun) n_both = n_both + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    tick();
    rx = 1'b0;
    start_cyc = cyc;
    repeat (bit_clks) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) tick();
    end
    rx = stop_bit;
    repeat (bit_clks) tick();
    rx = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (data !== 8'h00)     begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_held_low();
    int ferr0, nb0;
    ferr0 = n_ferr; nb0 = got_q.size();
    reset = 1'b1; rx = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (1100) tick();
    checks++; if (n_ferr - ferr0 !== 1) begin failures++; $display("FAIL held_low_ferr got=%0d exp=1", n_ferr - ferr0); end
    checks++; if (got_q.size() - nb0 !== 0) begin failures++; $display("FAIL held_low_bytes got=%0d exp=0", got_q.size() - nb0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_low_break_busy got=%b exp=1", busy); end
    rx = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_low_release_busy got=%b exp=0", busy); end
    checks++; if (n_ferr - ferr0 !== 1) begin failures++; $display("FAIL held_low_ferr_once got=%0d exp=1", n_ferr - ferr0); end
  endtask

  task automatic test_single();
    int nb0, vc0, ferr0, lat;
    nb0 = got_q.size(); vc0 = n_valid_cyc; ferr0 = n_ferr;
    ready = 1'b1;
    send(8'hA5, 1'b1, CBP);
    repeat (20) tick();
    checks++; if (got_q.size() - nb0 !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size() - nb0); end
    checks++; if (got_q.size() <= nb0 || got_q[nb0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", (got_q.size() > nb0) ? got_q[nb0] : 8'hxx); end
    lat = (got_cyc.size() > nb0) ? got_cyc[nb0] - start_cyc : -1;
    checks++; if (lat < 989 || lat > 993) begin failures++; $display("FAIL single_latency got=%0d exp=991+/-2", lat); end
    checks++; if (n_valid_cyc - vc0 !== 1) begin failures++; $display("FAIL single_valid_width got=%0d exp=1", n_valid_cyc - vc0); end
    checks++; if (n_ferr - ferr0 !== 0) begin failures++; $display("FAIL single_frame_err got=%0d exp=0", n_ferr - ferr0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [8];
    int nb0;
    msg = '{8'h54, 8'h50, 8'h4D, 8'h32, 8'h31, 8'h33, 8'h37, 8'h21};
    nb0 = got_q.size();
    for (int i = 0; i < 8; i++) send(msg[i], 1'b1, CBP);
    repeat (20) tick();
    checks++; if (got_q.size() - nb0 !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got_q.size() - nb0); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] g;
      g = (got_q.size() > nb0 + i) ? got_q[nb0 + i] : 8'hxx;
      checks++; if (g !== msg[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, g, msg[i]); end
    end
  endtask

  task automatic test_overrun();
    int nb0, ovr0;
    tick();
    ready = 1'b0;
    nb0 = got_q.size(); ovr0 = n_ovr;
    send(8'h11, 1'b1, CBP);
    send(8'h22, 1'b1, CBP);
    repeat (20) tick();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", data); end
    checks++; if (n_ovr - ovr0 !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - ovr0); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_valid got=%b exp=0", valid); end
    checks++; if (got_q.size() - nb0 !== 1 || got_q[got_q.size() - 1] !== 8'h11) begin
      failures++; $display("FAIL ovr_delivered count=%0d exp=1 byte 11", got_q.size() - nb0);
    end
  endtask

  task automatic test_glitch();
    int nb0, ferr0, waited;
    nb0 = got_q.size(); ferr0 = n_ferr;
    tick();
    rx = 1'b0;
    repeat (30) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
    rx = 1'b1;
    waited = 0;
    while (busy && waited <= CBP / 2 + 3) begin
      tick();
      waited++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_timeout got=%b after %0d clk exp=0", busy, waited); end
    repeat (200) tick();
    checks++; if (got_q.size() - nb0 !== 0) begin failures++; $display("FAIL glitch_bytes got=%0d exp=0", got_q.size() - nb0); end
    checks++; if (n_ferr - ferr0 !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", n_ferr - ferr0); end
  endtask

  task automatic test_frame_error();
    int nb0, ferr0;
    nb0 = got_q.size(); ferr0 = n_ferr;
    send(8'h3C, 1'b0, CBP);
    repeat (20) tick();
    checks++; if (n_ferr - ferr0 !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", n_ferr - ferr0); end
    checks++; if (got_q.size() - nb0 !== 0 || valid !== 1'b0) begin failures++; $display("FAIL ferr_no_valid bytes=%0d valid=%b exp=0,0", got_q.size() - nb0, valid); end
    send(8'h7E, 1'b1, CBP);
    repeat (20) tick();
    checks++; if (got_q.size() - nb0 !== 1 || got_q[got_q.size() - 1] !== 8'h7E) begin
      failures++; $display("FAIL ferr_recover count=%0d exp=1 byte 7e", got_q.size() - nb0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nb0, ferr0, ovr0;
    nb0 = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
    tick();
    rx = 1'b0;
    repeat (CBP) tick();
    rx = 1'b1;
    repeat (4 * CBP + CBP / 2) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_immediate valid=%b busy=%b exp=0,0", valid, busy); end
    repeat (5) tick();
    reset = 1'b0;
    repeat (5) tick();
    send(8'h01, 1'b1, CBP);
    repeat (20) tick();
    checks++; if (got_q.size() - nb0 !== 1 || got_q[got_q.size() - 1] !== 8'h01) begin
      failures++; $display("FAIL midrst_only_01 count=%0d exp=1 byte 01", got_q.size() - nb0);
    end
    checks++; if (n_ferr - ferr0 !== 0 || n_ovr - ovr0 !== 0) begin failures++; $display("FAIL midrst_flags ferr=%0d ovr=%0d exp=0,0", n_ferr - ferr0, n_ovr - ovr0); end
  endtask

  task automatic test_baud_tolerance();
    int nb0;
    nb0 = got_q.size();
    send(8'hC3, 1'b1, CBP - 2);
    send(8'h5A, 1'b1, CBP + 2);
    repeat (20) tick();
    checks++; if (got_q.size() - nb0 !== 2) begin failures++; $display("FAIL baud_count got=%0d exp=2", got_q.size() - nb0); end
    checks++; if (got_q.size() < nb0 + 2 || got_q[nb0] !== 8'hC3 || got_q[nb0 + 1] !== 8'h5A) begin
      failures++; $display("FAIL baud_data count=%0d exp bytes c3,5a", got_q.size() - nb0);
    end
  endtask

  task automatic test_flags_exclusive();
    checks++; if (n_both !== 0) begin failures++; $display("FAIL flags_exclusive got=%0d exp=0", n_both); end
  endtask

  initial begin
    test_reset();
    test_held_low();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_flags_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
